crypto_job_scheduler: RTL and testbench

CRYPTO_JOB_SCHEDULER -- requirements
Module: crypto_job_scheduler

---
 rtl/crypto_job_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_crypto_job_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_job_scheduler.sv
// Crypto job scheduler: queues one encrypt and one decrypt job, arbitrates them
// onto a single shared crypto core, and retires or aborts each launched job.
module crypto_job_scheduler #(
    parameter int TIMEOUT = 256
) (
    input  logic         TCK,
    input  logic         TRST,
    input  logic         encrypt_start,
    input  logic         decrypt_start,
    input  logic [127:0] test_config_plain,
    input  logic [127:0] nonce_enc,
    input  logic [127:0] test_config_cipher,
    input  logic [127:0] nonce_dec,
    input  logic [127:0] received_tag,
    input  logic         core_done,
    input  logic [127:0] core_result,
    input  logic [127:0] core_tag,
    output logic         core_start,
    output logic         core_mode,
    output logic [127:0] core_data,
    output logic [127:0] core_nonce,
    output logic         core_abort,
    output logic [127:0] encrypted_config,
    output logic [127:0] encryption_tag,
    output logic [127:0] decrypted_config,
    output logic         decryption_valid,
    output logic         enc_done,
    output logic         dec_done,
    output logic         sched_busy,
    output logic         req_overflow,
    output logic         timeout_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RETIRE} state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t       state, next_state;
    logic         enc_pend, dec_pend;
    logic [127:0] enc_plain, enc_nonce;
    logic [127:0] dec_cipher, dec_nonce, dec_tag;
    logic [127:0] job_tag;
    logic         last_grant, grant;
    logic [15:0]  wait_cnt;
    logic         done_hit, timeout_hit;
    logic         launch_enc, launch_dec, enc_busy, dec_busy;

    always_comb begin
        grant = MODE_ENC;
        if (enc_pend && dec_pend)
            grant = ~last_grant;
        else if (dec_pend)
            grant = MODE_DEC;
    end

    assign done_hit    = (state == ST_WAIT) && core_done;
    assign timeout_hit = (state == ST_WAIT) && !core_done && (wait_cnt == WAIT_LAST);

    // The slot being launched is released on the LAUNCH edge, so a fresh start
    // for the in-flight job type is accepted there instead of overflowing.
    assign launch_enc = (state == ST_LAUNCH) && (core_mode == MODE_ENC);
    assign launch_dec = (state == ST_LAUNCH) && (core_mode == MODE_DEC);
    assign enc_busy   = enc_pend && !launch_enc;
    assign dec_busy   = dec_pend && !launch_dec;

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        core_start = 1'b0;
        core_abort = 1'b0;
        enc_done   = 1'b0;
        dec_done   = 1'b0;
        sched_busy = 1'b1;
        case (state)
            ST_IDLE: begin
                sched_busy = 1'b0;
                if (enc_pend || dec_pend)
                    next_state = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                core_start = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                core_abort = timeout_hit;
                if (done_hit)
                    next_state = ST_RETIRE;
                else if (timeout_hit)
                    next_state = ST_IDLE;
            end
            ST_RETIRE: begin
                enc_done   = (core_mode == MODE_ENC);
                dec_done   = (core_mode == MODE_DEC);
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            enc_pend     <= 1'b0;
            dec_pend     <= 1'b0;
            enc_plain    <= '0;
            enc_nonce    <= '0;
            dec_cipher   <= '0;
            dec_nonce    <= '0;
            dec_tag      <= '0;
            req_overflow <= 1'b0;
        end else begin
            if (encrypt_start && !enc_busy) begin
                enc_pend  <= 1'b1;
                enc_plain <= test_config_plain;
                enc_nonce <= nonce_enc;
            end else if (launch_enc) begin
                enc_pend <= 1'b0;
            end
            if (decrypt_start && !dec_busy) begin
                dec_pend   <= 1'b1;
                dec_cipher <= test_config_cipher;
                dec_nonce  <= nonce_dec;
                dec_tag    <= received_tag;
            end else if (launch_dec) begin
                dec_pend <= 1'b0;
            end
            if ((encrypt_start && enc_busy) || (decrypt_start && dec_busy))
                req_overflow <= 1'b1;
        end
    end

    // Launched operands are captured when leaving IDLE so the slots can be
    // refilled while the core is still working on this job.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            core_mode  <= MODE_ENC;
            core_data  <= '0;
            core_nonce <= '0;
            job_tag    <= '0;
            last_grant <= MODE_DEC;
            wait_cnt   <= '0;
        end else begin
            if (state == ST_IDLE && (enc_pend || dec_pend)) begin
                core_mode  <= grant;
                last_grant <= grant;
                core_data  <= (grant == MODE_DEC) ? dec_cipher : enc_plain;
                core_nonce <= (grant == MODE_DEC) ? dec_nonce : enc_nonce;
                job_tag    <= dec_tag;
            end
            if (state == ST_LAUNCH)
                wait_cnt <= '0;
            else if (state == ST_WAIT)
                wait_cnt <= wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            encrypted_config <= '0;
            encryption_tag   <= '0;
            decrypted_config <= '0;
            decryption_valid <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            if (done_hit) begin
                if (core_mode == MODE_ENC) begin
                    encrypted_config <= core_result;
                    encryption_tag   <= core_tag;
                end else if (core_tag == job_tag) begin
                    decrypted_config <= core_result;
                    decryption_valid <= 1'b1;
                end else begin
                    decrypted_config <= '0;
                    decryption_valid <= 1'b0;
                end
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
                if (core_mode == MODE_DEC)
                    decryption_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_crypto_job_scheduler.sv
// Testbench for crypto_job_scheduler: directed scenarios plus a randomized run
// checked against a transaction-level model of the slots, arbiter and results.
module tb_crypto_job_scheduler;

    localparam int TO = 8;
    localparam logic [127:0] P11 = {16{8'h11}};
    localparam logic [127:0] N22 = {16{8'h22}};
    localparam logic [127:0] RAA = {16{8'hAA}};
    localparam logic [127:0] TBB = {16{8'hBB}};
    localparam logic [127:0] T55 = {16{8'h55}};
    localparam logic [127:0] T54 = {8'h54, {15{8'h55}}};

    logic         TCK = 1'b0, TRST = 1'b0;
    logic         encrypt_start = 1'b0, decrypt_start = 1'b0, core_done = 1'b0;
    logic [127:0] test_config_plain = '0, nonce_enc = '0;
    logic [127:0] test_config_cipher = '0, nonce_dec = '0, received_tag = '0;
    logic [127:0] core_result = '0, core_tag = '0;
    logic         core_start, core_mode, core_abort, decryption_valid;
    logic         enc_done, dec_done, sched_busy, req_overflow, timeout_err;
    logic [127:0] core_data, core_nonce, encrypted_config, encryption_tag, decrypted_config;

    int n_checks = 0;
    int n_fail   = 0;

    logic         m_pend [2];
    logic [127:0] m_data [2];
    logic [127:0] m_nonce [2];
    logic [127:0] m_rtag, m_enc_cfg, m_enc_tag, m_dec_cfg;
    logic         m_last, m_ovf, m_terr, m_dec_valid;

    crypto_job_scheduler #(.TIMEOUT(TO)) dut (
        .TCK(TCK), .TRST(TRST),
        .encrypt_start(encrypt_start), .decrypt_start(decrypt_start),
        .test_config_plain(test_config_plain), .nonce_enc(nonce_enc),
        .test_config_cipher(test_config_cipher), .nonce_dec(nonce_dec),
        .received_tag(received_tag),
        .core_done(core_done), .core_result(core_result), .core_tag(core_tag),
        .core_start(core_start), .core_mode(core_mode),
        .core_data(core_data), .core_nonce(core_nonce), .core_abort(core_abort),
        .encrypted_config(encrypted_config), .encryption_tag(encryption_tag),
        .decrypted_config(decrypted_config), .decryption_valid(decryption_valid),
        .enc_done(enc_done), .dec_done(dec_done), .sched_busy(sched_busy),
        .req_overflow(req_overflow), .timeout_err(timeout_err)
    );

    always #5 TCK = ~TCK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge TCK);
        #1;
    endtask

    task automatic clear_inputs();
        encrypt_start = 1'b0;
        decrypt_start = 1'b0;
        core_done     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        TRST = 1'b1;
        repeat (2) @(posedge TCK);
        #1;
        TRST = 1'b0;
    endtask

    task automatic push_enc(input logic [127:0] d, input logic [127:0] n);
        encrypt_start = 1'b1;
        test_config_plain = d;
        nonce_enc = n;
    endtask

    task automatic push_dec(input logic [127:0] d, input logic [127:0] n, input logic [127:0] t);
        decrypt_start = 1'b1;
        test_config_cipher = d;
        nonce_dec = n;
        received_tag = t;
    endtask

    // Called in the LAUNCH cycle; raises core_done in WAIT cycle k (k > TO never
    // answers) and returns in the IDLE cycle that follows the job.
    task automatic serve(input int k, input logic [127:0] res, input logic [127:0] tag,
                         output int abort_cyc, output int n_abort, output int n_enc, output int n_dec);
        abort_cyc = 0; n_abort = 0; n_enc = 0; n_dec = 0;
        step();
        for (int c = 1; c <= k && c <= TO; c++) begin
            if (c == k) begin
                core_done = 1'b1; core_result = res; core_tag = tag;
            end
            #1;
            if (core_abort) begin n_abort++; abort_cyc = c; end
            n_enc += int'(enc_done); n_dec += int'(dec_done);
            step();
            core_done = 1'b0;
        end
        n_enc += int'(enc_done); n_dec += int'(dec_done);
        if (k <= TO) begin
            step();
            n_enc += int'(enc_done); n_dec += int'(dec_done);
        end
    endtask

    task automatic test_reset();
        logic [660:0] all_out;
        repeat (2) @(posedge TCK);
        #1;
        TRST = 1'b1;
        #1;
        all_out = {core_start, core_mode, core_data, core_nonce, core_abort, encrypted_config, encryption_tag,
                   decrypted_config, decryption_valid, enc_done, dec_done, sched_busy, req_overflow, timeout_err};
        n_checks++; if (all_out !== '0) begin n_fail++; $display("[TB] FAIL reset_outputs: got %0h expected 0", all_out); end
        @(posedge TCK); #1;
        TRST = 1'b0;
    endtask

    task automatic test_encrypt();
        int ac, na, ne, nd;
        do_reset();
        push_enc(P11, N22); step(); clear_inputs();
        n_checks++; if (sched_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL enc_idle_after_request: got %0b expected 0", sched_busy); end
        step();
        n_checks++; if ({core_start, core_mode, sched_busy} !== 3'b101) begin n_fail++; $display("[TB] FAIL enc_launch: got %b expected 101", {core_start, core_mode, sched_busy}); end
        n_checks++; if ({core_data, core_nonce} !== {P11, N22}) begin n_fail++; $display("[TB] FAIL enc_operands: got %h %h expected %h %h", core_data, core_nonce, P11, N22); end
        serve(5, RAA, TBB, ac, na, ne, nd);
        n_checks++; if ({encrypted_config, encryption_tag} !== {RAA, TBB}) begin n_fail++; $display("[TB] FAIL enc_result: got %h %h expected %h %h", encrypted_config, encryption_tag, RAA, TBB); end
        n_checks++; if (ne != 1 || nd != 0 || na != 0) begin n_fail++; $display("[TB] FAIL enc_pulses: got enc=%0d dec=%0d abort=%0d expected 1 0 0", ne, nd, na); end
    endtask

    task automatic test_decrypt();
        int ac, na, ne, nd;
        logic [127:0] r1, r2;
        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom, $urandom};
        do_reset();
        push_dec(128'h1234, 128'h5678, T55); step(); clear_inputs(); step();
        n_checks++; if ({core_start, core_mode} !== 2'b11) begin n_fail++; $display("[TB] FAIL dec_launch: got %b expected 11", {core_start, core_mode}); end
        serve(3, r1, T55, ac, na, ne, nd);
        n_checks++; if ({decryption_valid, decrypted_config} !== {1'b1, r1}) begin n_fail++; $display("[TB] FAIL dec_match: got %b %h expected 1 %h", decryption_valid, decrypted_config, r1); end
        n_checks++; if (nd != 1 || ne != 0) begin n_fail++; $display("[TB] FAIL dec_pulses: got dec=%0d enc=%0d expected 1 0", nd, ne); end
        push_dec(128'h9abc, 128'hdef0, T55); step(); clear_inputs(); step();
        serve(2, r2, T54, ac, na, ne, nd);
        n_checks++; if ({decryption_valid, decrypted_config} !== {1'b0, 128'h0}) begin n_fail++; $display("[TB] FAIL dec_mismatch: got %b %h expected 0 0", decryption_valid, decrypted_config); end
    endtask

    task automatic test_simultaneous();
        int ac, na, ne, nd;
        do_reset();
        push_enc(128'hE1, 128'hE1E1); push_dec(128'hD1, 128'hD1D1, T55); step(); clear_inputs(); step();
        n_checks++; if ({core_start, core_mode, core_data} !== {2'b10, 128'hE1}) begin n_fail++; $display("[TB] FAIL sim_enc_first: got %b %b %h expected 1 0 e1", core_start, core_mode, core_data); end
        step();
        push_enc(128'hE2, 128'hE2E2); push_dec(128'hD2, 128'hD2D2, T55); step(); clear_inputs();
        core_done = 1'b1; core_result = RAA; core_tag = TBB; step(); core_done = 1'b0;
        n_checks++; if (enc_done !== 1'b1) begin n_fail++; $display("[TB] FAIL sim_enc_retire: got %b expected 1", enc_done); end
        step();
        n_checks++; if ({core_start, sched_busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL sim_idle_gap: got %b expected 00", {core_start, sched_busy}); end
        step();
        n_checks++; if ({core_start, core_mode, core_data} !== {2'b11, 128'hD1}) begin n_fail++; $display("[TB] FAIL sim_dec_second: got %b %b %h expected 1 1 d1", core_start, core_mode, core_data); end
        serve(2, RAA, T55, ac, na, ne, nd);
        step();
        n_checks++; if ({core_start, core_mode, core_data} !== {2'b10, 128'hE2}) begin n_fail++; $display("[TB] FAIL sim_enc_requeued: got %b %b %h expected 1 0 e2", core_start, core_mode, core_data); end
        serve(2, RAA, TBB, ac, na, ne, nd);
        n_checks++; if (req_overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL sim_overflow_flag: got %b expected 1", req_overflow); end
    endtask

    task automatic test_overflow();
        int ac, na, ne, nd;
        do_reset();
        push_dec(128'hCA, 128'h1, T55); step(); clear_inputs();
        n_checks++; if (req_overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_clear_before: got %b expected 0", req_overflow); end
        push_dec(128'hCB, 128'h2, T55); step(); clear_inputs();
        n_checks++; if (req_overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_set: got %b expected 1", req_overflow); end
        n_checks++; if ({core_start, core_data, core_nonce} !== {1'b1, 128'hCA, 128'h1}) begin n_fail++; $display("[TB] FAIL ovf_first_kept: got %b %h %h expected 1 ca 1", core_start, core_data, core_nonce); end
        serve(3, RAA, T55, ac, na, ne, nd);
    endtask

    task automatic test_timeout();
        int ac, na, ne, nd;
        do_reset();
        push_dec(128'h77, 128'h88, T55); step(); clear_inputs(); step();
        serve(2, RAA, T55, ac, na, ne, nd);
        push_dec(128'h99, 128'h88, T55); step(); clear_inputs(); step();
        serve(TO + 5, RAA, T55, ac, na, ne, nd);
        n_checks++; if (ac != TO || na != 1) begin n_fail++; $display("[TB] FAIL to_abort_cycle: got cycle %0d count %0d expected %0d 1", ac, na, TO); end
        n_checks++; if (nd != 0) begin n_fail++; $display("[TB] FAIL to_no_done: got %0d expected 0", nd); end
        n_checks++; if ({timeout_err, sched_busy, decryption_valid} !== 3'b100) begin n_fail++; $display("[TB] FAIL to_flags: got %b expected 100", {timeout_err, sched_busy, decryption_valid}); end
    endtask

    task automatic test_reset_mid_wait();
        int ac, na, ne, nd;
        logic [660:0] all_out;
        do_reset();
        push_enc(P11, N22); step(); clear_inputs(); step();
        serve(1, RAA, TBB, ac, na, ne, nd);
        push_enc(N22, P11); step(); clear_inputs(); step(); step(); step();
        TRST = 1'b1;
        #1;
        all_out = {core_start, core_mode, core_data, core_nonce, core_abort, encrypted_config, encryption_tag,
                   decrypted_config, decryption_valid, enc_done, dec_done, sched_busy, req_overflow, timeout_err};
        n_checks++; if (all_out !== '0) begin n_fail++; $display("[TB] FAIL midwait_reset_outputs: got %0h expected 0", all_out); end
        @(posedge TCK); #1;
        TRST = 1'b0;
        core_done = 1'b1; core_result = RAA; core_tag = TBB; step(); core_done = 1'b0;
        step();
        n_checks++; if ({enc_done, sched_busy, core_abort, encrypted_config} !== '0) begin n_fail++; $display("[TB] FAIL midwait_done_ignored: got %b %b %b %h expected all 0", enc_done, sched_busy, core_abort, encrypted_config); end
    endtask

    task automatic rand_start(input int which);
        logic [127:0] d, n, t;
        d = {$urandom, $urandom, $urandom, $urandom};
        n = {$urandom, $urandom, $urandom, $urandom};
        t = {$urandom, $urandom, $urandom, $urandom};
        if (which == 0) push_enc(d, n);
        else push_dec(d, n, t);
        if (m_pend[which]) m_ovf = 1'b1;
        else begin
            m_pend[which] = 1'b1; m_data[which] = d; m_nonce[which] = n;
            if (which == 1) m_rtag = t;
        end
    endtask

    task automatic maybe_starts();
        if ($urandom_range(0, 3) == 0) rand_start(0);
        if ($urandom_range(0, 3) == 0) rand_start(1);
    endtask

    task automatic test_random();
        int g, k, got;
        logic [127:0] res, tag, fl_tag;
        logic [1:0] exp_done;
        logic exp_abort;
        do_reset();
        m_pend[0] = 1'b0; m_pend[1] = 1'b0; m_last = 1'b1; m_ovf = 1'b0; m_terr = 1'b0;
        m_enc_cfg = '0; m_enc_tag = '0; m_dec_cfg = '0; m_dec_valid = 1'b0; m_rtag = '0;
        for (int j = 0; j < 60; j++) begin
            if (!m_pend[0] && !m_pend[1]) begin
                rand_start(int'($urandom_range(0, 1))); step(); clear_inputs();
            end
            g = (m_pend[0] && m_pend[1]) ? (m_last ? 0 : 1) : (m_pend[1] ? 1 : 0);
            got = 0;
            for (int w = 0; w < 4 && got == 0; w++) begin
                step();
                if (core_start === 1'b1) got = 1;
            end
            n_checks++; if (got != 1) begin n_fail++; $display("[TB] FAIL rnd_launch: no core_start within 4 cycles (job %0d)", j); break; end
            n_checks++; if ({core_mode, core_data, core_nonce} !== {g[0], m_data[g], m_nonce[g]}) begin n_fail++; $display("[TB] FAIL rnd_launch_ops: got %b %h %h expected %b %h %h", core_mode, core_data, core_nonce, g[0], m_data[g], m_nonce[g]); end
            m_pend[g] = 1'b0; m_last = g[0]; fl_tag = m_rtag;
            k = int'($urandom_range(1, TO + 2));
            res = {$urandom, $urandom, $urandom, $urandom};
            tag = {$urandom, $urandom, $urandom, $urandom};
            if (g == 1 && $urandom_range(0, 1) == 1) tag = fl_tag;
            maybe_starts(); step(); clear_inputs();
            for (int c = 1; c <= k && c <= TO; c++) begin
                maybe_starts();
                if (c == k) begin core_done = 1'b1; core_result = res; core_tag = tag; end
                exp_abort = (k > TO) && (c == TO);
                #1;
                n_checks++; if (core_abort !== exp_abort) begin n_fail++; $display("[TB] FAIL rnd_abort: job %0d cycle %0d got %b expected %b", j, c, core_abort, exp_abort); end
                step(); clear_inputs();
            end
            if (k <= TO) begin
                if (g == 0) begin m_enc_cfg = res; m_enc_tag = tag; end
                else if (tag == fl_tag) begin m_dec_cfg = res; m_dec_valid = 1'b1; end
                else begin m_dec_cfg = '0; m_dec_valid = 1'b0; end
                exp_done = (g == 0) ? 2'b10 : 2'b01;
            end else begin
                m_terr = 1'b1;
                if (g == 1) m_dec_valid = 1'b0;
                exp_done = 2'b00;
            end
            n_checks++; if ({enc_done, dec_done} !== exp_done) begin n_fail++; $display("[TB] FAIL rnd_done_pulse: job %0d got %b expected %b", j, {enc_done, dec_done}, exp_done); end
            n_checks++; if ({encrypted_config, encryption_tag, decrypted_config, decryption_valid, req_overflow, timeout_err} !== {m_enc_cfg, m_enc_tag, m_dec_cfg, m_dec_valid, m_ovf, m_terr}) begin
                n_fail++; $display("[TB] FAIL rnd_results: job %0d got %h %h %h %b%b%b expected %h %h %h %b%b%b", j, encrypted_config, encryption_tag, decrypted_config, decryption_valid, req_overflow, timeout_err, m_enc_cfg, m_enc_tag, m_dec_cfg, m_dec_valid, m_ovf, m_terr);
            end
            if (k <= TO) step();
            n_checks++; if (sched_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_idle: job %0d got %b expected 0", j, sched_busy); end
        end
    endtask

    initial begin
        $display("[TB] crypto_job_scheduler bench start");
        test_reset();
        test_encrypt();
        test_decrypt();
        test_simultaneous();
        test_overflow();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
